// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: one shared BCD nibble plus a one-hot digit enable, frame-synchronous value update.
// Optional leading-zero blanking when SEG_LZB_EN is defined (blanked digits output 4'hF).
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  output logic                    load_ack,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int DW   = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         active_q, active_d;
  logic [DW-1:0]         pend_val_q, pend_val_d;
  logic                  pend_q, pend_d;
  logic                  load_ack_q, load_ack_d;
  logic                  frame_done_q, frame_done_d;
  logic [3:0]            bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  transfer;

  function automatic logic [3:0] disp_nib(input logic [DW-1:0] a, input logic [IW-1:0] k);
    logic [DW-1:0] s;
    s = a >> {k, 2'b00};
`ifdef SEG_LZB_EN
    // everything from digit k upward is zero: this is a leading zero
    if (k != '0 && s == '0) return 4'hF;
`endif
    return s[3:0];
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    if (state_q == BLANK) begin
      if (cnt_q == BLANK_LAST) begin
        state_d = SHOW;
        cnt_d   = '0;
      end
    end else if (cnt_q == SHOW_LAST) begin
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      state_d = (BLANK_CYCLES == 0) ? SHOW : BLANK;
      cnt_d   = '0;
    end

    // frame_done_q marks the current cycle as the last of the frame
    transfer   = frame_done_q && (pend_q || load);
    active_d   = active_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    if (transfer) begin
      active_d = load ? value_in : pend_val_q;
      pend_d   = 1'b0;
    end else if (load) begin
      pend_val_d = value_in;
      pend_d     = 1'b1;
    end
    load_ack_d = transfer;

    frame_done_d = (state_d == SHOW) && (idx_d == IDX_LAST) && (cnt_d == SHOW_LAST);
    digit_en_d   = (state_d == SHOW) ? (NUM_DIGITS'(1) << idx_d) : '0;
    bcd_d        = disp_nib(active_d, idx_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= (BLANK_CYCLES == 0) ? SHOW : BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      active_q     <= '0;
      pend_val_q   <= '0;
      pend_q       <= 1'b0;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
      bcd_q        <= '0;
      digit_en_q   <= (BLANK_CYCLES == 0) ? NUM_DIGITS'(1) : '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      pend_val_q   <= pend_val_d;
      pend_q       <= pend_d;
      load_ack_q   <= load_ack_d;
      frame_done_q <= frame_done_d;
      bcd_q        <= bcd_d;
      digit_en_q   <= digit_en_d;
    end
  end

  assign load_ack   = load_ack_q;
  assign bcd_out    = bcd_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with 4 digits, 4 show cycles, 2 blank cycles; honours SEG_LZB_EN.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic        load_ack;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_en;
  logic        frame_done;

  seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in),
    .load_ack(load_ack), .bcd_out(bcd_out), .digit_en(digit_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t;
  logic [15:0] m_active, m_pend_val;
  bit          m_pend, m_ack;
  int          ack_count, last_ack_cycle;
  logic [3:0]  shown [4];

  typedef struct {
    int          c1;
    logic [15:0] v1;
    int          c2;
    logic [15:0] v2;
    int          exp_acks;
    int          exp_ack_cycle;
    logic [15:0] exp_val;
  } vec_t;

  vec_t vecs [5];

  // Display rule: nibble d of the value, leading zeros blanked to F when enabled.
  function automatic logic [3:0] exp_nib(logic [15:0] a, int d);
    logic [15:0] s;
    s = a >> (4 * d);
`ifdef SEG_LZB_EN
    if (d > 0 && s == 16'h0) return 4'hF;
`endif
    return s[3:0];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t = 1; m_active = '0; m_pend_val = '0; m_pend = 0; m_ack = 0;
    ack_count = 0; last_ack_cycle = -1;
    for (int d = 0; d < 4; d++) shown[d] = 'x;
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; value_in = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Cycle t spans from just after posedge t-1 to posedge t; outputs checked at the negedge.
  task automatic run_cycle(bit ld, logic [15:0] v);
    int pos, dig, ph;
    load = ld; value_in = v;
    @(negedge clk);
    pos = (t - 1) % 24; dig = pos / 6; ph = pos % 6;
    check("digit_en", 32'(digit_en), (ph >= 2) ? (32'd1 << dig) : 32'd0);
    check("bcd_out", 32'(bcd_out), 32'(exp_nib(m_active, dig)));
    check("frame_done", 32'(frame_done), 32'(pos == 23));
    check("load_ack", 32'(load_ack), 32'(m_ack));
    if (load_ack) begin ack_count++; last_ack_cycle = t; end
    for (int d = 0; d < 4; d++) if (digit_en[d] && t > 24) shown[d] = bcd_out;
    m_ack = 0;
    if (pos == 23 && (m_pend || ld)) begin
      m_active = ld ? v : m_pend_val; m_pend = 0; m_ack = 1;
    end else if (ld) begin
      m_pend_val = v; m_pend = 1;
    end
    @(posedge clk);
    #1 t++;
  endtask

  task automatic check_outputs_zero(string name);
    check({name, "_en"},  32'(digit_en), 32'd0);
    check({name, "_bcd"}, 32'(bcd_out), 32'd0);
    check({name, "_ack"}, 32'(load_ack), 32'd0);
    check({name, "_fd"},  32'(frame_done), 32'd0);
  endtask

  initial begin
    vecs[0] = '{c1: 0,  v1: 16'h0000, c2: 0,  v2: 16'h0000, exp_acks: 0, exp_ack_cycle: -1, exp_val: 16'h0000};
    vecs[1] = '{c1: 7,  v1: 16'h1234, c2: 0,  v2: 16'h0000, exp_acks: 1, exp_ack_cycle: 25, exp_val: 16'h1234};
    vecs[2] = '{c1: 3,  v1: 16'h1111, c2: 10, v2: 16'h9876, exp_acks: 1, exp_ack_cycle: 25, exp_val: 16'h9876};
    vecs[3] = '{c1: 24, v1: 16'h0005, c2: 0,  v2: 16'h0000, exp_acks: 1, exp_ack_cycle: 25, exp_val: 16'h0005};
    vecs[4] = '{c1: 23, v1: 16'h0A0C, c2: 24, v2: 16'h0070, exp_acks: 1, exp_ack_cycle: 25, exp_val: 16'h0070};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      for (int c = 1; c <= 48; c++)
        run_cycle(c == vecs[i].c1 || c == vecs[i].c2, (c == vecs[i].c1) ? vecs[i].v1 : vecs[i].v2);
      check("ack_count", 32'(ack_count), 32'(vecs[i].exp_acks));
      check("ack_cycle", 32'(last_ack_cycle), 32'(vecs[i].exp_ack_cycle));
      for (int d = 0; d < 4; d++) check("shown_digit", 32'(shown[d]), 32'(exp_nib(vecs[i].exp_val, d)));
    end

    // Asynchronous reset mid-cycle, then restart of the scan.
    do_reset();
    for (int c = 1; c <= 10; c++) run_cycle(c == 4, 16'h5678);
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int c = 1; c <= 8; c++) run_cycle(0, 16'h0);

    // Reset during digit-2 SHOW with a pending value: value and ack are lost.
    do_reset();
    for (int c = 1; c <= 15; c++) run_cycle(c == 5, 16'h4321);
    #2 rst = 1'b1;
    #1 check_outputs_zero("rst_show2");
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int c = 1; c <= 48; c++) run_cycle(0, 16'h0);
    check("rst_pend_acks", 32'(ack_count), 32'd0);
    for (int d = 0; d < 4; d++) check("rst_pend_shown", 32'(shown[d]), 32'(exp_nib(16'h0, d)));

    // Randomised loads, including nibbles above 9 and loads on frame boundaries.
    do_reset();
    for (int c = 1; c <= 600; c++) begin
      bit ld;
      ld = ($urandom_range(0, 7) == 0) || ((((t - 1) % 24) == 23) && $urandom_range(0, 1) == 1);
      run_cycle(ld, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
